// File: rtl/bus_arbiter.sv
// Round-robin arbiter that runs one strobed read/write bus transaction at a time.
// Latency: grant 1 cycle after req is seen in IDLE; done at 2+STROBE_CYCLES; STROBE_CYCLES+3 cycles per transaction.
// Backpressure: requesters hold req until done; requests are only sampled in IDLE, and later changes are ignored.
module bus_arbiter #(
    parameter int NREQ          = 3,
    parameter int ADDR_W        = 16,
    parameter int STROBE_CYCLES = 2
) (
    input  logic                   Clk,
    input  logic                   nReset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_wr,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    output logic [NREQ-1:0]        grant,
    output logic [NREQ-1:0]        done,
    output logic [ADDR_W-1:0]      address,
    output logic                   nRead,
    output logic                   nWrite,
    output logic                   busy
);

    localparam int         IDX_W       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ADDR    = 2'd1,
        S_STROBE  = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic [NREQ-1:0]     done_q, done_d;
    logic                nread_q, nread_d;
    logic                nwrite_q, nwrite_d;
    logic                busy_q, busy_d;

    logic                win_vld;
    logic [IDX_W-1:0]    win_idx;
    logic                win_wr;
    logic [ADDR_W-1:0]   win_addr;
    logic [NREQ-1:0]     owner_onehot;

    // Round-robin pick: the candidate closest after last_q wins, so scan from farthest to nearest.
    always_comb begin
        logic [IDX_W-1:0] cand;
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_q) + k) % NREQ);
            if (req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Select the winner's direction and address slice with constant part-selects.
    always_comb begin
        win_wr   = 1'b0;
        win_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDX_W'(i) == win_idx) begin
                win_wr   = req_wr[i];
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Next-state logic; outputs are decoded from the next state so they come straight off flops.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        owner_d  = owner_q;
        wr_d     = wr_q;
        addr_d   = addr_q;

        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    owner_d = win_idx;
                    wr_d    = win_wr;
                    addr_d  = win_addr;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                cnt_d   = '0;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RELEASE: begin
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        owner_onehot = NREQ'(1) << owner_d;
        grant_d      = (state_d != S_IDLE)    ? owner_onehot : '0;
        done_d       = (state_d == S_RELEASE) ? owner_onehot : '0;
        nread_d      = !((state_d == S_STROBE) && !wr_d);
        nwrite_d     = !((state_d == S_STROBE) &&  wr_d);
        busy_d       = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any transaction without a done pulse.
    always_ff @(posedge Clk) begin
        if (nReset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            last_q   <= IDX_W'(NREQ - 1);
            owner_q  <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            nread_q  <= 1'b1;
            nwrite_q <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            nread_q  <= nread_d;
            nwrite_q <= nwrite_d;
            busy_q   <= busy_d;
        end
    end

    assign grant   = grant_q;
    assign done    = done_q;
    assign address = addr_q;
    assign nRead   = nread_q;
    assign nWrite  = nwrite_q;
    assign busy    = busy_q;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameters SHALL be: NREQ, default 3, number of requesters (0 Execution, 1 MatrixAlu, 2 IntegerAlu); ADDR_W, default 16, bus address width; STROBE_CYCLES, default 2, strobe low time in cycles, legal range 1..15.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be, clock and reset first:
- Clk  in  1  rising-edge clock.
- nReset  in  1  synchronous reset; 1 = reset, despite the n prefix.
- req  in  NREQ  per-requester transaction request level.
- req_wr  in  NREQ  per-requester direction; 1 = write, 0 = read.
- req_addr  in  NREQ*ADDR_W  per-requester address; requester i uses bits [i*ADDR_W +: ADDR_W].
- grant  out  NREQ  one-hot bus ownership.
- done  out  NREQ  one-cycle completion pulse to the owner.
- address  out  ADDR_W  shared bus address.
- nRead  out  1  read strobe, active low.
- nWrite  out  1  write strobe, active low.
- busy  out  1  high when the FSM is not in IDLE.

Function
REQ-004 All outputs SHALL be registered Moore outputs of a four-state FSM: IDLE, ADDR, STROBE, RELEASE.
REQ-005 In IDLE, with any req bit high, the arbiter SHALL pick the winner round-robin, searching from (last_owner+1) mod NREQ upward with wrap.
- On that edge it latches the winner's req_wr and req_addr and moves to ADDR.
- With no req bit high it stays in IDLE.
REQ-006 ADDR SHALL last exactly 1 cycle: grant one-hot to the winner, address equal to the latched address, nRead=nWrite=1; then STROBE.
REQ-007 STROBE SHALL last exactly STROBE_CYCLES cycles, counted by an internal counter.
- nRead=0 for a read, or nWrite=0 for a write; grant and address held; then RELEASE.
REQ-008 RELEASE SHALL last exactly 1 cycle.
- nRead=nWrite=1, grant held, done bit of the owner high.
- last_owner updated to the owner; then IDLE.
REQ-009 Latency: req sampled in IDLE in cycle 0 -> grant at cycle 1, strobe low in cycles 2..1+STROBE_CYCLES, done at cycle 2+STROBE_CYCLES, grant low at cycle 3+STROBE_CYCLES.
REQ-010 Back-to-back throughput SHALL be one transaction per STROBE_CYCLES+3 cycles, including one mandatory IDLE cycle between owners.
REQ-011 nRead and nWrite SHALL never be low simultaneously, and SHALL never be low outside STROBE.
REQ-012 address SHALL stay stable from ADDR through RELEASE, and SHALL hold its last value in IDLE.
REQ-013 grant SHALL be zero or one-hot at all times; done SHALL be zero or one-hot, and only the bit matching grant may be high.
REQ-014 req, req_wr and req_addr changes after acceptance SHALL be ignored.
- A req dropped mid-transaction does not abort; the transaction completes and done still pulses.
REQ-015 A requester holding req high through its own done SHALL be treated as a new request; round-robin order gives other pending requesters priority first.
REQ-016 Simultaneous requests SHALL be resolved solely by the round-robin rule of REQ-005, with no fixed priority except the post-reset pointer.
REQ-017 busy SHALL be 1 in ADDR, STROBE and RELEASE, and 0 in IDLE.

Reset
REQ-018 nReset=1 at a rising edge SHALL force, from the next cycle:
- state IDLE, strobe counter 0, last_owner NREQ-1 so requester 0 has first priority;
- grant 0, done 0, address 0, nRead 1, nWrite 1, busy 0.
REQ-019 Reset asserted in any state, including mid-STROBE, SHALL abandon the transaction with no done pulse.
REQ-020 While nReset=1, req SHALL be ignored; arbitration resumes on the first edge with nReset=0.

Verification
REQ-021 Single read (STROBE_CYCLES=2): req=001, req_wr=0, address 0x0005 after reset.
- grant=001 cycles 1-4, address=0x0005 cycles 1-4, nRead=0 cycles 2-3, done=001 cycle 4, nWrite=1 throughout, grant=000 cycle 5.
REQ-022 Round-robin under full load: req=111 held.
- grants in order 001, 010, 100, 001, each new grant 5 cycles after the previous one, with no overlap.
REQ-023 Fairness with a repeating requester: requester 1 writes address 0x0010 while requester 2 is pending, and req[1] is held after its done.
- nWrite=0 for 2 cycles; next grant=100, then 010.
REQ-024 Reset mid-operation: nReset=1 during the first STROBE cycle of a requester-2 read, with req=101 pending after release.
- next cycle nRead=1, grant=0, busy=0, no done pulse; after release, grant=001 first.
REQ-025 Request withdrawal: req[0] dropped during ADDR.
- STROBE and RELEASE still occur, done=001 pulses, then the FSM returns to IDLE.
REQ-026 Parameter corner STROBE_CYCLES=1: single write.
- nWrite low exactly 1 cycle, done at cycle 3, next grant possible at cycle 5.
